// File: rtl/snake_pkg.sv
// snake_pkg: shared constants and types for the snake direction controller.
// Holds the direction encoding, PS/2 set-2 scancodes and the prefix FSM states.
package snake_pkg;

    localparam int unsigned DIR_W = 2;
    localparam int unsigned SC_W  = 8;

    // Direction encoding
    localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd1;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd2;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd3;

    // Set-2 scancodes
    localparam logic [SC_W-1:0] SC_EXT    = 8'hE0;
    localparam logic [SC_W-1:0] SC_BRK    = 8'hF0;
    localparam logic [SC_W-1:0] SC_SPACE  = 8'h29;
    localparam logic [SC_W-1:0] SC_ARR_UP = 8'h75;
    localparam logic [SC_W-1:0] SC_ARR_RT = 8'h74;
    localparam logic [SC_W-1:0] SC_ARR_DN = 8'h72;
    localparam logic [SC_W-1:0] SC_ARR_LT = 8'h6B;
    localparam logic [SC_W-1:0] SC_KEY_W  = 8'h1D;
    localparam logic [SC_W-1:0] SC_KEY_D  = 8'h23;
    localparam logic [SC_W-1:0] SC_KEY_S  = 8'h1B;
    localparam logic [SC_W-1:0] SC_KEY_A  = 8'h1C;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_e;

    // Opposite directions differ only in bit 1
    function automatic logic is_reversal(input logic [DIR_W-1:0] a,
                                         input logic [DIR_W-1:0] b);
        return a == (b ^ 2'd2);
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// dir_fifo: DEPTH x 2-bit synchronous FIFO holding queued snake turns.
// Ports: clk_i, rst_ni (sync, active-low), push_i/data_i, pop_i,
//        full_o, empty_o, head_o (oldest entry, valid when !empty_o).
// A push while full is accepted when a pop happens in the same cycle.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [DIR_W-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [DIR_W-1:0] head_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DIR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage needs no reset; only pointers define validity
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: PS/2 set-2 keyboard to snake direction controller.
// Tracks E0/F0 prefixes, maps arrow (and optionally WASD) make codes to turns,
// rejects repeats and reversals, queues turns and releases one per tick.
// Ports: CLK, rst_n (sync, active-low), scancode/strobe from the decoder,
//        tick (game step), dir, dir_valid, paused, overflow (sticky).
// Build option: define SNAKE_WASD_EN to also steer with W/A/S/D.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter logic [DIR_W-1:0] RESET_DIR = 2'd1
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [SC_W-1:0]  scancode,
    input  logic             strobe,
    input  logic             tick,
    output logic [DIR_W-1:0] dir,
    output logic             dir_valid,
    output logic             paused,
    output logic             overflow
);

    prefix_state_e    state_q, state_d;
    logic             strobe_q;
    logic [DIR_W-1:0] last_q, last_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic             dir_valid_q, dir_valid_d;
    logic             paused_q, paused_d;
    logic             overflow_q, overflow_d;

    logic             byte_ev;
    logic             key_valid;
    logic [DIR_W-1:0] key_dir;
    logic             space_hit;
    logic             turn_ok, do_pop, push, drop;
    logic             fifo_full, fifo_empty;
    logic [DIR_W-1:0] fifo_head;

    assign byte_ev = strobe & ~strobe_q;

    // Prefix FSM state register
    always_ff @(posedge CLK) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Prefix FSM next state and make-code decode
    always_comb begin
        state_d   = state_q;
        key_valid = 1'b0;
        key_dir   = DIR_UP;
        space_hit = 1'b0;
        if (byte_ev) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scancode == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (scancode == SC_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        space_hit = (scancode == SC_SPACE);
`ifdef SNAKE_WASD_EN
                        key_valid = 1'b1;
                        unique case (scancode)
                            SC_KEY_W: key_dir = DIR_UP;
                            SC_KEY_D: key_dir = DIR_RIGHT;
                            SC_KEY_S: key_dir = DIR_DOWN;
                            SC_KEY_A: key_dir = DIR_LEFT;
                            default:  key_valid = 1'b0;
                        endcase
`endif
                    end
                end
                ST_EXT: begin
                    if (scancode == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (scancode == SC_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d   = ST_IDLE;
                        key_valid = 1'b1;
                        unique case (scancode)
                            SC_ARR_UP: key_dir = DIR_UP;
                            SC_ARR_RT: key_dir = DIR_RIGHT;
                            SC_ARR_DN: key_dir = DIR_DOWN;
                            SC_ARR_LT: key_dir = DIR_LEFT;
                            default:   key_valid = 1'b0;
                        endcase
                    end
                end
                // Byte after a break prefix is the released key: discard it
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Turn acceptance, queue control and output next-state
    always_comb begin
        turn_ok = key_valid & ~paused_q
                & (key_dir != last_q) & ~is_reversal(key_dir, last_q);
        do_pop  = tick & ~paused_q & ~fifo_empty;
        push    = turn_ok & (~fifo_full | do_pop);
        drop    = turn_ok & fifo_full & ~do_pop;

        last_d      = push ? key_dir : last_q;
        dir_d       = dir_q;
        dir_valid_d = 1'b0;
        if (tick && !paused_q) begin
            dir_valid_d = 1'b1;
            if (!fifo_empty) dir_d = fifo_head;
        end
        paused_d   = paused_q ^ space_hit;
        overflow_d = overflow_q | drop;
    end

    // strobe_q resets high so a strobe held across reset is not a new byte
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            strobe_q    <= 1'b1;
            last_q      <= RESET_DIR;
            dir_q       <= RESET_DIR;
            dir_valid_q <= 1'b0;
            paused_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            strobe_q    <= strobe;
            last_q      <= last_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            paused_q    <= paused_d;
            overflow_q  <= overflow_d;
        end
    end

    dir_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (key_dir),
        .pop_i   (do_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign dir       = dir_q;
    assign dir_valid = dir_valid_q;
    assign paused    = paused_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: scoreboard bench for snake_dir_ctrl.
// Every tick that should be applied pushes its expected direction; the
// monitor pops one entry per dir_valid pulse and compares dir.
module tb_snake_dir_ctrl;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic [7:0] scancode;
    logic       strobe;
    logic       tick;
    logic [1:0] dir;
    logic       dir_valid;
    logic       paused;
    logic       overflow;

    int checks      = 0;
    int failures    = 0;
    int pulses      = 0;
    int exp_pulses  = 0;
    logic [1:0] exp_q[$];
    logic [1:0] cur;

    always #5 CLK = ~CLK;

    snake_dir_ctrl #(
        .FIFO_DEPTH (2),
        .RESET_DIR  (2'd1)
    ) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .scancode  (scancode),
        .strobe    (strobe),
        .tick      (tick),
        .dir       (dir),
        .dir_valid (dir_valid),
        .paused    (paused),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (rst_n === 1'b1 && dir_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", int'(dir_valid), 0);
            end else begin
                chk("tick_dir", int'(dir), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold = 1);
        @(negedge CLK);
        scancode = b;
        strobe   = 1'b1;
        repeat (hold - 1) @(negedge CLK);
        @(negedge CLK);
        strobe = 1'b0;
    endtask

    task automatic do_tick(input bit pulse, input logic [1:0] d);
        @(negedge CLK);
        tick = 1'b1;
        if (pulse) begin
            exp_q.push_back(d);
            exp_pulses++;
        end
        @(negedge CLK);
        tick = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        scancode = 8'h00;
        strobe   = 1'b0;
        tick     = 1'b0;
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        // Reset values
        chk("rst_dir", int'(dir), 1);
        chk("rst_dir_valid", int'(dir_valid), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_overflow", int'(overflow), 0);

        // Empty-queue tick keeps RESET_DIR; then UP
        do_tick(1, 2'd1);
        send_byte(8'hE0); send_byte(8'h75, 3);
        do_tick(1, 2'd0);
        send_byte(8'hE0); send_byte(8'h74);
        do_tick(1, 2'd1);

        // Reversal and repeat rejected
        send_byte(8'hE0); send_byte(8'h6B);
        do_tick(1, 2'd1);
        send_byte(8'hE0); send_byte(8'h74);
        do_tick(1, 2'd1);

        // Double tap within one tick period
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h6B);
        do_tick(1, 2'd0);
        do_tick(1, 2'd3);

        // Release sequence ignored, FSM back in IDLE
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        do_tick(1, 2'd3);
        send_byte(8'hE0); send_byte(8'h72);
        do_tick(1, 2'd2);

        // Back to RIGHT, then overflow the two-entry queue
        send_byte(8'hE0); send_byte(8'h74);
        do_tick(1, 2'd1);
        chk("no_ovf_yet", int'(overflow), 0);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h72);
        chk("overflow_set", int'(overflow), 1);

        // UP together with a tick on a full queue: pop UP, enqueue UP
        send_byte(8'hE0);
        @(negedge CLK);
        scancode = 8'h75;
        strobe   = 1'b1;
        tick     = 1'b1;
        exp_q.push_back(2'd0);
        exp_pulses++;
        @(negedge CLK);
        strobe = 1'b0;
        tick   = 1'b0;
        chk("overflow_sticky", int'(overflow), 1);
        do_tick(1, 2'd3);
        do_tick(1, 2'd0);
        do_tick(1, 2'd0);

        // Normal-code D steers only with WASD enabled
`ifdef SNAKE_WASD_EN
        cur = 2'd1;
`else
        cur = 2'd0;
`endif
        send_byte(8'h23);
        do_tick(1, cur);

        // Pause: long space press toggles once, ticks and turns ignored
        send_byte(8'h29, 4);
        chk("paused_on", int'(paused), 1);
        do_tick(0, 2'd0);
        send_byte(8'hE0); send_byte(8'h72);
        send_byte(8'hE0); send_byte(8'h6B);
        do_tick(0, 2'd0);
        chk("paused_dir", int'(dir), int'(cur));
        send_byte(8'h29);
        chk("paused_off", int'(paused), 0);
        do_tick(1, cur);

        // Queue a turn, then reset with strobe held high across deassert
        send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h75);
        @(negedge CLK);
        rst_n    = 1'b0;
        scancode = 8'h29;
        strobe   = 1'b1;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        repeat (3) @(negedge CLK);
        strobe = 1'b0;
        @(negedge CLK);
        chk("held_strobe_paused", int'(paused), 0);
        chk("rst2_dir", int'(dir), 1);
        chk("rst2_overflow", int'(overflow), 0);
        do_tick(1, 2'd1);

        repeat (4) @(negedge CLK);
        chk("pending_ticks", exp_q.size(), 0);
        chk("pulse_count", pulses, exp_pulses);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
